alu_seq: RTL

- Parametrised, clocked successor of the CPU's combinational ALU, for the multi-cycle datapath.
- Keeps the existing 4-bit control encoding and zero flag.
- Adds:
  - configurable width;
  - registered start/busy/done handshake;
  - signed compare and shifts;
  - signed overflow flag;
  - iterative unsigned multiply, divide and remainder.
- Sits between the register-file read stage and write-back; the control FSM stalls on busy.

---
 rtl/alu_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a start/busy/done handshake.
// Logic and compare ops finish in one cycle. MULU, DIVU and REMU run one
// shift-add or restoring-subtract step per cycle for WIDTH cycles.
// WIDTH must be >= 4 and a power of two. SHW is derived from WIDTH and is
// not meant to be overridden.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow
);

   // The 4-bit opcodes are unchanged from the combinational ALU.
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MULU = 4'b1101;
   localparam logic [3:0] OP_DIVU = 4'b1110;
   localparam logic [3:0] OP_REMU = 4'b1111;

   // The counter must be able to hold WIDTH itself, so it is SHW+1 bits wide.
   localparam int                 CNT_W    = SHW + 1;
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [3:0]         op_q,        op_d;
   logic [WIDTH-1:0]   hi_q,        hi_d;       // MULU accumulator / DIVU remainder
   logic [WIDTH-1:0]   lo_q,        lo_d;       // MULU multiplier / DIVU quotient
   logic [WIDTH-1:0]   opb_q,       opb_d;      // multiplicand or divisor
   logic [WIDTH-1:0]   result_q,    result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               zero_q,      zero_d;
   logic               ovf_q,       ovf_d;

   // Single-cycle datapath signals.
   logic [WIDTH-1:0]   add_sum;
   logic [WIDTH-1:0]   sub_diff;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   imm_res;
   logic               imm_ovf;
   logic               is_iter;

   // Iterative step signals.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi;
   logic [WIDTH-1:0]   mul_lo;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_hi;
   logic [WIDTH-1:0]   div_lo;
   logic [WIDTH-1:0]   fin_res;
   logic [WIDTH-1:0]   fin_hi;

   // Single-cycle result, computed straight from the operands being accepted.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      add_sum  = In1 + In2;
      sub_diff = In1 - In2;
      shamt    = In2[SHW-1:0];
      imm_res  = '0;
      imm_ovf  = 1'b0;
      is_iter  = (control == OP_MULU) || (control == OP_DIVU) || (control == OP_REMU);
      case (control)
         OP_AND:  imm_res = In1 & In2;
         OP_OR:   imm_res = In1 | In2;
         OP_NOR:  imm_res = ~(In1 | In2);
         OP_ADD: begin
            imm_res = add_sum;
            imm_ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (add_sum[WIDTH-1] != In1[WIDTH-1]);
         end
         OP_SUB: begin
            imm_res = sub_diff;
            imm_ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (sub_diff[WIDTH-1] != In1[WIDTH-1]);
         end
         OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
         OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
         OP_SLL:  imm_res = In1 << shamt;
         OP_SRL:  imm_res = In1 >> shamt;
         OP_SRA:  imm_res = $unsigned($signed(In1) >>> shamt);
         default: imm_res = '0;    // undefined codes and the iterative ops
      endcase
   end

   // One multiply or divide step, computed from the working registers.
   always_comb begin
      // Shift-add: add the multiplicand when the multiplier LSB is set,
      // then shift {acc, multiplier} right by one.
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
      // Restoring divide: shift the next dividend bit into the remainder, and
      // subtract when the result stays non-negative. A zero divisor always
      // subtracts, so the quotient becomes all ones and the remainder becomes In1.
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
      div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_lo    = {lo_q[WIDTH-2:0], div_ge};
      fin_res   = '0;
      fin_hi    = '0;
      case (op_q)
         OP_MULU: begin
            fin_res = mul_lo;
            fin_hi  = mul_hi;
         end
         OP_DIVU: fin_res = div_lo;
         default: fin_res = div_hi;   // REMU
      endcase
   end

   // Next-state and output-register logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opb_d       = opb_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = control;
               if (is_iter) begin
                  hi_d    = '0;
                  lo_d    = In1;
                  opb_d   = In2;
                  cnt_d   = CNT_INIT;
                  state_d = S_RUN;
               end else begin
                  result_d    = imm_res;
                  result_hi_d = '0;
                  zero_d      = (imm_res == '0);
                  ovf_d       = imm_ovf;
                  state_d     = S_DONE;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (op_q == OP_MULU) begin
               hi_d = mul_hi;
               lo_d = mul_lo;
            end else begin
               hi_d = div_hi;
               lo_d = div_lo;
            end
            // The last step writes the outputs, so they become visible in the DONE cycle.
            if (cnt_q == CNT_ONE) begin
               result_d    = fin_res;
               result_hi_d = fin_hi;
               zero_d      = (fin_res == '0);
               ovf_d       = 1'b0;
               state_d     = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
      if (reset) begin
         // NOTE: the working registers are reset too. There are only a few of them, and this keeps simulation free of X values.
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opb_q       <= opb_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;

endmodule
